cpu_run_ctrl: RTL and testbench

- Parametrised clock/reset sequencer and LED display mux for the 6502 core.
- Derives the CPU clock `cpu_clk` from the board clock `CLK` through a programmable prescaler.
- Holds CPU reset for a configurable delay, then runs free, single-steps, or stops after a fixed number of half-cycles.
- Drives 8 LEDs from one of NUM_SRC selectable 8-bit CPU buses (A, X, Y, P, S, …).

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/btn_sync_edge.sv | 19 +
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the 6502 run controller: sequencer states and display width.
package cpu_ctrl_pkg;

  localparam int LED_W = 8;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    STEP_IDLE,
    STEP_HI,
    DONE
  } run_st_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the step button followed by a rising-edge detector.
module btn_sync_edge (
  input  logic CLK,
  input  logic R,
  input  logic btn,
  output logic pulse
);

  // sync[1:0] is the metastability chain, sync[2] the previous synchronised level
  logic [2:0] sync;

  always_ff @(posedge CLK) begin
    if (R) sync <= '0;
    else   sync <= {sync[1:0], btn};
  end

  assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU clock/reset sequencer (prescaler, run/step/stop FSM) and registered LED source mux.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV         = 1,
  parameter int START_DLY   = 100,
  parameter int STOP_HALVES = 0,
  parameter int CNT_W       = 32,
  parameter int NUM_SRC     = 8,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     CLK,
  input  logic                     R,
  input  logic                     step_mode,
  input  logic                     step_btn,
  input  logic                     halt,
  input  logic [NUM_SRC*LED_W-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  output logic                     cpu_clk,
  output logic                     cpu_res,
  output logic [CNT_W-1:0]         half_cnt,
  output logic                     done,
  output logic [LED_W-1:0]         led
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(DIV - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] STOP_AT    = CNT_W'(STOP_HALVES);

  run_st_t                           st;
  logic [PRE_W-1:0]                  pre;
  logic [CNT_W-1:0]                  start_cnt;
  logic                              pending;
  logic                              step_pulse;
  logic                              tick;
  logic                              start_last;
  logic [CNT_W-1:0]                  hc_inc;
  logic                              stop_hit;
  logic [NUM_SRC-1:0][LED_W-1:0]     src;
  logic [LED_W-1:0]                  led_nxt;

  btn_sync_edge u_btn (
    .CLK   (CLK),
    .R     (R),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  assign tick       = !halt && (pre == PRE_MAX);
  assign start_last = (START_DLY == 0) || (start_cnt == START_LAST);
  assign hc_inc     = half_cnt + CNT_W'(1);
  assign stop_hit   = (STOP_HALVES != 0) && (hc_inc == STOP_AT);

  assign src = src_bus;

  always_comb begin
    led_nxt = '0;
    if (int'(sel) < NUM_SRC) led_nxt = src[sel];
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      st        <= HOLD;
      pre       <= '0;
      start_cnt <= '0;
      pending   <= 1'b0;
      cpu_clk   <= 1'b0;
      cpu_res   <= 1'b1;
      half_cnt  <= '0;
      done      <= 1'b0;
      led       <= '0;
    end else begin
      led <= led_nxt;
      // halt freezes the whole sequencer, including the step-mode check
      if (!halt) begin
        pre <= tick ? '0 : pre + PRE_W'(1);
        case (st)
          HOLD: begin
            if (tick) begin
              start_cnt <= start_cnt + CNT_W'(1);
              if (start_last) begin
                cpu_res <= 1'b0;
                st      <= step_mode ? STEP_IDLE : RUN;
              end
            end
          end
          RUN: begin
            if (tick) begin
              cpu_clk  <= ~cpu_clk;
              half_cnt <= hc_inc;
              if (stop_hit) begin
                st   <= DONE;
                done <= 1'b1;
              end else if (cpu_clk && step_mode) begin
                st <= STEP_IDLE;
              end
            end
          end
          STEP_IDLE: begin
            if (!step_mode) begin
              st      <= RUN;
              pending <= 1'b0;
            end else if (tick && (pending || step_pulse)) begin
              // a fresh edge on a tick cycle fires directly to keep latency at 3 cycles
              cpu_clk  <= 1'b1;
              half_cnt <= hc_inc;
              pending  <= 1'b0;
              st       <= stop_hit ? DONE : STEP_HI;
              done     <= stop_hit;
            end else if (step_pulse) begin
              pending <= 1'b1;
            end
          end
          STEP_HI: begin
            if (tick) begin
              cpu_clk  <= 1'b0;
              half_cnt <= hc_inc;
              st       <= stop_hit ? DONE : STEP_IDLE;
              done     <= stop_hit;
            end
          end
          DONE: begin
            st <= DONE;
          end
          default: st <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: several parameterisations side by side on one clock.
module tb_cpu_run_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // u0: start-up, mode switch, LED mux
  logic r0 = 1'b1, sm0 = 1'b0, halt0 = 1'b0;
  logic [39:0] src0 = '0;
  logic [2:0]  sel0 = '0;
  logic clk0, res0, done0;
  logic [31:0] hc0;
  logic [7:0]  led0;
  cpu_run_ctrl #(.DIV(1), .START_DLY(4), .STOP_HALVES(0), .CNT_W(32), .NUM_SRC(5)) u0 (
    .CLK(CLK), .R(r0), .step_mode(sm0), .step_btn(1'b0), .halt(halt0), .src_bus(src0),
    .sel(sel0), .cpu_clk(clk0), .cpu_res(res0), .half_cnt(hc0), .done(done0), .led(led0));

  // u1: prescaler and halt
  logic r1 = 1'b1, halt1 = 1'b0;
  logic clk1, res1, done1;
  logic [31:0] hc1;
  logic [7:0]  led1;
  cpu_run_ctrl #(.DIV(3), .START_DLY(0), .STOP_HALVES(0), .CNT_W(32), .NUM_SRC(8)) u1 (
    .CLK(CLK), .R(r1), .step_mode(1'b0), .step_btn(1'b0), .halt(halt1), .src_bus(64'd0),
    .sel(3'd0), .cpu_clk(clk1), .cpu_res(res1), .half_cnt(hc1), .done(done1), .led(led1));

  // u2: stop count
  logic r2 = 1'b1, halt2 = 1'b0;
  logic clk2, res2, done2;
  logic [31:0] hc2;
  logic [7:0]  led2;
  cpu_run_ctrl #(.DIV(1), .START_DLY(2), .STOP_HALVES(7), .CNT_W(32), .NUM_SRC(8)) u2 (
    .CLK(CLK), .R(r2), .step_mode(1'b0), .step_btn(1'b0), .halt(halt2), .src_bus(64'd0),
    .sel(3'd0), .cpu_clk(clk2), .cpu_res(res2), .half_cnt(hc2), .done(done2), .led(led2));

  // u3: single step
  logic r3 = 1'b1, btn3 = 1'b0;
  logic clk3, res3, done3;
  logic [31:0] hc3;
  logic [7:0]  led3;
  cpu_run_ctrl #(.DIV(2), .START_DLY(1), .STOP_HALVES(0), .CNT_W(32), .NUM_SRC(8)) u3 (
    .CLK(CLK), .R(r3), .step_mode(1'b1), .step_btn(btn3), .halt(1'b0), .src_bus(64'd0),
    .sel(3'd0), .cpu_clk(clk3), .cpu_res(res3), .half_cnt(hc3), .done(done3), .led(led3));

  // u4: narrow counter wrap
  logic r4 = 1'b1;
  logic clk4, res4, done4;
  logic [3:0] hc4;
  logic [7:0] led4;
  cpu_run_ctrl #(.DIV(1), .START_DLY(1), .STOP_HALVES(0), .CNT_W(4), .NUM_SRC(8)) u4 (
    .CLK(CLK), .R(r4), .step_mode(1'b0), .step_btn(1'b0), .halt(1'b0), .src_bus(64'd0),
    .sel(3'd0), .cpu_clk(clk4), .cpu_res(res4), .half_cnt(hc4), .done(done4), .led(led4));

  // Free-run reference: n = non-halted CLK edges since reset release.
  // Returns {cpu_res, cpu_clk, done, half_cnt[31:0]}.
  function automatic logic [34:0] model(int n, int div, int sdly, int stop, int cntw);
    int ticks = n / div;
    int hold  = (sdly == 0) ? 1 : sdly;
    logic r;
    longint h;
    r = (ticks < hold);
    h = r ? 0 : longint'(ticks - hold);
    if (stop != 0 && h > stop) h = stop;
    h = h % (longint'(1) << cntw);
    return {r, h[0], (stop != 0 && h == stop), h[31:0]};
  endfunction

  int n0;  // u0 model edge count, carried from start-up into the mode test

  task automatic test_reset;
    logic [34:0] got;
    sel0 = 3'd3;
    src0 = 40'hAA_BB_CC_DD_EE;
    repeat (2) @(posedge CLK);
    #1;
    got = {res0, clk0, done0, hc0};
    if (got !== {1'b1, 1'b0, 1'b0, 32'd0} || led0 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_u0 got=%h led=%h exp=%h led=00", got, led0, {3'b100, 32'd0});
    end
    n_cmp++;
    got = {res1 & res2 & res3 & res4, clk1 | clk2 | clk3 | clk4, done1 | done2 | done3 | done4,
           hc1 | hc2 | hc3 | {28'd0, hc4}};
    if (got !== {3'b100, 32'd0} || (led1 | led2 | led3 | led4) !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_others got=%h exp=%h", got, {3'b100, 32'd0});
    end
    n_cmp++;
  endtask

  task automatic test_start;
    logic [34:0] got, exp;
    r0 = 1'b0;
    n0 = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge CLK);
      n0++;
      #1;
      got = {res0, clk0, done0, hc0};
      exp = model(n0, 1, 4, 0, 32);
      if (got !== exp) begin
        n_bad++;
        $display("FAIL start cyc=%0d got=%h exp=%h", i, got, exp);
      end
      n_cmp++;
    end
    if (hc0 !== 32'd10) begin
      n_bad++;
      $display("FAIL start_half got=%0d exp=10", hc0);
    end
    n_cmp++;
  endtask

  task automatic test_mode;
    logic [34:0] got, exp;
    int h, target;
    repeat ($urandom_range(3, 9)) begin
      @(posedge CLK);
      n0++;
      #1;
      got = {res0, clk0, done0, hc0};
      exp = model(n0, 1, 4, 0, 32);
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mode_pre got=%h exp=%h", got, exp);
      end
      n_cmp++;
    end
    h = n0 - 4;
    // clk high: one more toggle to 0; clk low: rise then fall before stopping
    target = (h % 2 == 1) ? h + 1 : h + 2;
    sm0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      h = (h + 1 > target) ? target : h + 1;
      got = {res0, clk0, done0, hc0};
      exp = {1'b0, h[0], 1'b0, 32'(h)};
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mode_to_step cyc=%0d got=%h exp=%h", i, got, exp);
      end
      n_cmp++;
    end
    sm0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      if (i > 0) h++;
      got = {res0, clk0, done0, hc0};
      exp = {1'b0, h[0], 1'b0, 32'(h)};
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mode_to_run cyc=%0d got=%h exp=%h", i, got, exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_prescale;
    logic [34:0] got, exp;
    int n = 0;
    r1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      halt1 = (c >= 60 && c < 65) ? 1'b1 : ($urandom_range(0, 4) == 0);
      @(posedge CLK);
      if (!halt1) n++;
      #1;
      got = {res1, clk1, done1, hc1};
      exp = model(n, 3, 0, 0, 32);
      if (got !== exp) begin
        n_bad++;
        $display("FAIL prescale cyc=%0d halt=%0b got=%h exp=%h", c, halt1, got, exp);
      end
      n_cmp++;
    end
    halt1 = 1'b0;
  endtask

  task automatic test_stop;
    logic [34:0] got, exp;
    int n = 0;
    r2 = 1'b0;
    for (int c = 0; c < 90; c++) begin
      halt2 = ($urandom_range(0, 5) == 0);
      @(posedge CLK);
      if (!halt2) n++;
      #1;
      got = {res2, clk2, done2, hc2};
      exp = model(n, 1, 2, 7, 32);
      if (got !== exp) begin
        n_bad++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", c, got, exp);
      end
      n_cmp++;
    end
    halt2 = 1'b0;
    if ({done2, clk2, hc2} !== {2'b11, 32'd7}) begin
      n_bad++;
      $display("FAIL stop_frozen done=%0b clk=%0b half=%0d exp 1 1 7", done2, clk2, hc2);
    end
    n_cmp++;
    r2 = 1'b1;
    @(posedge CLK);
    #1;
    r2 = 1'b0;
    got = {res2, clk2, done2, hc2};
    if (got !== {3'b100, 32'd0}) begin
      n_bad++;
      $display("FAIL stop_rereset got=%h exp=%h", got, {3'b100, 32'd0});
    end
    n_cmp++;
  endtask

  task automatic test_wrap;
    logic [34:0] got, exp;
    int n = 0;
    r4 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      n++;
      #1;
      got = {res4, clk4, done4, 28'd0, hc4};
      exp = model(n, 1, 1, 0, 4);
      if (got !== exp) begin
        n_bad++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", c, got, exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_step;
    int exp_h = 0;
    int lat, hi, rises, waited;
    logic prev;
    r3 = 1'b0;
    waited = 0;
    while (res3 !== 1'b0 && waited < 20) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (res3 !== 1'b0) begin
      n_bad++;
      $display("FAIL step_release timeout res=%0b exp=0", res3);
    end
    n_cmp++;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(4, 10)) @(posedge CLK);
      #1;
      btn3 = 1'b1;
      lat = 0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge CLK);
        #1;
        if (i == 2) btn3 = 1'b0;
        if (clk3 === 1'b1) begin
          if (lat == 0) lat = i + 1;
          hi++;
        end
      end
      exp_h += 2;
      if (lat < 1 || lat > 4) begin
        n_bad++;
        $display("FAIL step_latency press=%0d got=%0d exp<=4", k, lat);
      end
      n_cmp++;
      if (hi != 2 || hc3 !== 32'(exp_h) || clk3 !== 1'b0) begin
        n_bad++;
        $display("FAIL step_pulse press=%0d width=%0d half=%0d clk=%0b exp 2 %0d 0",
                 k, hi, hc3, clk3, exp_h);
      end
      n_cmp++;
    end
    // second edge lands while the first step is pending or high
    repeat ($urandom_range(4, 8)) @(posedge CLK);
    #1;
    btn3 = 1'b1;
    @(posedge CLK);
    #1;
    btn3 = 1'b0;
    @(posedge CLK);
    #1;
    btn3 = 1'b1;
    hi = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge CLK);
      #1;
      if (i == 3) btn3 = 1'b0;
      if (clk3 === 1'b1) hi++;
      if (clk3 === 1'b1 && prev === 1'b0) rises++;
      prev = clk3;
    end
    exp_h += 2;
    if (rises != 1 || hi != 2 || hc3 !== 32'(exp_h)) begin
      n_bad++;
      $display("FAIL step_drop rises=%0d width=%0d half=%0d exp 1 2 %0d", rises, hi, hc3, exp_h);
    end
    n_cmp++;
  endtask

  task automatic test_led;
    logic [7:0] exp;
    src0 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    sel0 = 3'd3;
    @(posedge CLK);
    #1;
    if (led0 !== 8'h13) begin
      n_bad++;
      $display("FAIL led_sel3 got=%h exp=13", led0);
    end
    n_cmp++;
    sel0 = 3'd6;
    @(posedge CLK);
    #1;
    if (led0 !== 8'h00) begin
      n_bad++;
      $display("FAIL led_sel6 got=%h exp=00", led0);
    end
    n_cmp++;
    for (int i = 0; i < 20; i++) begin
      src0 = {8'($urandom), 32'($urandom)};
      sel0 = 3'($urandom_range(0, 7));
      exp = (sel0 < 3'd5) ? src0[sel0*8 +: 8] : 8'h00;
      @(posedge CLK);
      #1;
      if (led0 !== exp) begin
        n_bad++;
        $display("FAIL led_rand sel=%0d got=%h exp=%h", sel0, led0, exp);
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_mode;
    test_prescale;
    test_stop;
    test_wrap;
    test_step;
    test_led;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
